traffic_light_ctrl: RTL and testbench

Parametrised two-road traffic-light controller; successor to the fixed-timing RGB light sequencer.
- Adds a tick prescaler, parametrised phase durations and all-red clearance phases.
- Adds a latched pedestrian-walk request and a night mode with flashing yellow.
- Drives the two on-board RGB LEDs with the existing encoding (R,G,B): red=100, green=010, yellow=110, off=000.

---
 rtl/traffic_light_ctrl_if.sv | 21 ++
 rtl/traffic_light_ctrl.sv | 162 ++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the traffic-light controller and its environment.
// Carries the night/pedestrian requests in and the lamp/debug outputs out.
interface traffic_light_ctrl_if;
  logic       night_mode;
  logic       ped_req;
  logic [2:0] RGB1;
  logic [2:0] RGB2;
  logic       walk;
  logic       ped_pending;
  logic [2:0] state_o;

  modport master (
    output night_mode, ped_req,
    input  RGB1, RGB2, walk, ped_pending, state_o
  );

  modport slave (
    input  night_mode, ped_req,
    output RGB1, RGB2, walk, ped_pending, state_o
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light controller with tick prescaler, pedestrian walk
// phase and flashing-yellow night mode.
// Ports: clk, reset (sync, active-high); bus.slave = night_mode, ped_req in;
//        RGB1, RGB2 {R,G,B}, walk, ped_pending, state_o out.
module traffic_light_ctrl #(
  parameter int CLK_DIV  = 100000000,
  parameter int T_GREEN  = 12,
  parameter int T_YELLOW = 5,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 8,
  parameter int CNT_W    = 8
) (
  input logic clk,
  input logic reset,
  traffic_light_ctrl_if.slave bus
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] GRN = 3'b010;
  localparam logic [2:0] YEL = 3'b110;
  localparam logic [2:0] OFF = 3'b000;

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR1   = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR2   = 3'd5,
    WALK  = 3'd6,
    FLASH = 3'd7
  } state_e;

  state_e           st_q, st_d;
  logic [DW-1:0]    div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, t_last;
  logic             ped_q, ped_d;
  logic             blink_q, blink_d;
  logic             nb_q, nb_d;
  logic             tick, term;
  logic [2:0]       rgb1, rgb2;
  logic             walk_l;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= AR2;
      div_q   <= '0;
      cnt_q   <= '0;
      ped_q   <= 1'b0;
      blink_q <= 1'b0;
      nb_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
      blink_q <= blink_d;
      nb_q    <= nb_d;
    end
  end

  always_comb begin
    tick  = (div_q == DIV_MAX);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_comb begin
    t_last = '0;
    case (st_q)
      A_GRN, B_GRN: t_last = CNT_W'(T_GREEN - 1);
      A_YEL, B_YEL: t_last = CNT_W'(T_YELLOW - 1);
      AR1, AR2:     t_last = CNT_W'(T_ALLRED - 1);
      WALK:         t_last = CNT_W'(T_WALK - 1);
      default:      t_last = '0;
    endcase
    term = (cnt_q == t_last);
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    ped_d   = ped_q;
    blink_d = blink_q;
    nb_d    = nb_q;

    // Requests are dropped while walking or flashing.
    if (bus.ped_req && st_q != WALK && st_q != FLASH)
      ped_d = 1'b1;
    if (st_q == FLASH)
      ped_d = 1'b0;

    if (tick) begin
      cnt_d = term ? '0 : cnt_q + 1'b1;
      case (st_q)
        A_GRN: begin
          if (bus.night_mode || term) begin
            st_d  = A_YEL;
            cnt_d = '0;
          end
        end
        B_GRN: begin
          if (bus.night_mode || term) begin
            st_d  = B_YEL;
            cnt_d = '0;
          end
        end
        A_YEL: if (term) st_d = AR1;
        B_YEL: if (term) st_d = AR2;
        AR1, AR2: begin
          if (term) begin
            if (bus.night_mode) begin
              st_d    = FLASH;
              ped_d   = 1'b0;
              blink_d = 1'b1;
            end else if (ped_q) begin
              st_d  = WALK;
              ped_d = 1'b0;
              nb_d  = (st_q == AR1);
            end else begin
              st_d = (st_q == AR1) ? B_GRN : A_GRN;
            end
          end
        end
        WALK: if (term) st_d = nb_q ? B_GRN : A_GRN;
        FLASH: begin
          cnt_d   = '0;
          blink_d = ~blink_q;
          if (!bus.night_mode) st_d = AR2;
        end
        default: st_d = AR2;
      endcase
    end
  end

  always_comb begin
    rgb1   = RED;
    rgb2   = RED;
    walk_l = 1'b0;
    case (st_q)
      A_GRN: rgb1 = GRN;
      A_YEL: rgb1 = YEL;
      B_GRN: rgb2 = GRN;
      B_YEL: rgb2 = YEL;
      WALK:  walk_l = 1'b1;
      FLASH: begin
        rgb1 = blink_q ? YEL : OFF;
        rgb2 = blink_q ? YEL : OFF;
      end
      default: ;
    endcase
  end

  assign bus.RGB1        = rgb1;
  assign bus.RGB2        = rgb2;
  assign bus.walk        = walk_l;
  assign bus.ped_pending = ped_q;
  assign bus.state_o     = st_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: expected lamp/state words are
// queued per cycle and popped against the DUT on the falling edge.
module tb_traffic_light_ctrl;

  typedef logic [10:0] obs_t;

  localparam int AG = 0;
  localparam int AY = 1;
  localparam int R1 = 2;
  localparam int BG = 3;
  localparam int BY = 4;
  localparam int R2 = 5;
  localparam int WK = 6;
  localparam int FL = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  traffic_light_ctrl_if ifa ();
  traffic_light_ctrl_if ifb ();

  traffic_light_ctrl #(
    .CLK_DIV(1), .T_GREEN(4), .T_YELLOW(2),
    .T_ALLRED(1), .T_WALK(3), .CNT_W(8)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(ifa)
  );

  traffic_light_ctrl #(
    .CLK_DIV(4), .T_GREEN(4), .T_YELLOW(2),
    .T_ALLRED(1), .T_WALK(3), .CNT_W(8)
  ) u_dut4 (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  obs_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(string tag, obs_t got, obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t ex(int s, logic bl, logic pd);
    logic [2:0] r1, r2;
    logic w;
    r1 = 3'b100;
    r2 = 3'b100;
    w  = 1'b0;
    case (s)
      AG: r1 = 3'b010;
      AY: r1 = 3'b110;
      BG: r2 = 3'b010;
      BY: r2 = 3'b110;
      WK: w = 1'b1;
      FL: begin
        r1 = bl ? 3'b110 : 3'b000;
        r2 = r1;
      end
      default: ;
    endcase
    return {3'(s), r1, r2, w, pd};
  endfunction

  task automatic step(string tag, int sel, obs_t e);
    obs_t got;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sel == 0)
      got = {ifa.state_o, ifa.RGB1, ifa.RGB2,
             ifa.walk, ifa.ped_pending};
    else
      got = {ifb.state_o, ifb.RGB1, ifb.RGB2,
             ifb.walk, ifb.ped_pending};
    chk(tag, got, q.pop_front());
  endtask

  task automatic run(string tag, int sel, int s, int n, logic pd);
    for (int i = 0; i < n; i++)
      step(tag, sel, ex(s, 1'b0, pd));
  endtask

  task automatic rst(string tag, int sel);
    reset = 1'b1;
    step(tag, sel, ex(R2, 1'b0, 1'b0));
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ifa.night_mode = 1'b0;
    ifa.ped_req    = 1'b0;
    ifb.night_mode = 1'b0;
    ifb.ped_req    = 1'b0;
    @(negedge clk);

    // normal cycle, two full periods
    rst("reset", 0);
    for (int p = 0; p < 2; p++) begin
      run("n_ag", 0, AG, 4, 0);
      run("n_ay", 0, AY, 2, 0);
      run("n_r1", 0, R1, 1, 0);
      run("n_bg", 0, BG, 4, 0);
      run("n_by", 0, BY, 2, 0);
      run("n_r2", 0, R2, 1, 0);
    end

    // pedestrian pulse in A_GRN, walk after AR1
    rst("p_rst", 0);
    run("p_ag0", 0, AG, 1, 0);
    ifa.ped_req = 1'b1;
    run("p_set", 0, AG, 1, 1);
    ifa.ped_req = 1'b0;
    run("p_ag", 0, AG, 2, 1);
    run("p_ay", 0, AY, 2, 1);
    run("p_r1", 0, R1, 1, 1);
    run("p_walk", 0, WK, 3, 0);
    run("p_bg", 0, BG, 4, 0);
    run("p_by", 0, BY, 2, 0);
    run("p_r2", 0, R2, 1, 0);
    run("p_ag2", 0, AG, 1, 0);

    // night mode cuts green, then flashing
    rst("f_rst", 0);
    run("f_ag", 0, AG, 1, 0);
    ifa.night_mode = 1'b1;
    run("f_ay", 0, AY, 2, 0);
    run("f_r1", 0, R1, 1, 0);
    step("f_on1", 0, ex(FL, 1'b1, 1'b0));
    ifa.ped_req = 1'b1;
    step("f_off1", 0, ex(FL, 1'b0, 1'b0));
    step("f_on2", 0, ex(FL, 1'b1, 1'b0));
    step("f_off2", 0, ex(FL, 1'b0, 1'b0));
    ifa.night_mode = 1'b0;
    run("f_r2", 0, R2, 1, 0);
    ifa.ped_req = 1'b0;
    run("f_ag2", 0, AG, 2, 0);

    // night beats pending walk at AR1 terminal tick
    rst("w_rst", 0);
    run("w_ag", 0, AG, 4, 0);
    run("w_ay0", 0, AY, 1, 0);
    ifa.ped_req = 1'b1;
    run("w_ay1", 0, AY, 1, 1);
    ifa.ped_req = 1'b0;
    run("w_r1", 0, R1, 1, 1);
    ifa.night_mode = 1'b1;
    ifa.ped_req = 1'b1;
    step("w_fl1", 0, ex(FL, 1'b1, 1'b0));
    ifa.ped_req = 1'b0;
    step("w_fl0", 0, ex(FL, 1'b0, 1'b0));
    ifa.night_mode = 1'b0;
    run("w_r2", 0, R2, 1, 0);
    run("w_ag2", 0, AG, 1, 0);

    // reset during B_GRN
    rst("b_rst", 0);
    run("b_ag", 0, AG, 4, 0);
    run("b_ay", 0, AY, 2, 0);
    run("b_r1", 0, R1, 1, 0);
    run("b_bg", 0, BG, 2, 0);
    rst("b_mid", 0);
    run("b_ag2", 0, AG, 4, 0);
    run("b_ay2", 0, AY, 1, 0);

    // reset during WALK
    rst("k_rst", 0);
    ifa.ped_req = 1'b1;
    run("k_ag0", 0, AG, 1, 1);
    ifa.ped_req = 1'b0;
    run("k_ag", 0, AG, 3, 1);
    run("k_ay", 0, AY, 2, 1);
    run("k_r1", 0, R1, 1, 1);
    run("k_walk", 0, WK, 2, 0);
    rst("k_mid", 0);
    run("k_ag2", 0, AG, 2, 0);

    // prescaler: every phase is 4x longer
    rst("d_rst", 1);
    run("d_r2", 1, R2, 3, 0);
    run("d_ag", 1, AG, 16, 0);
    run("d_ay", 1, AY, 8, 0);
    run("d_r1", 1, R1, 4, 0);
    run("d_bg", 1, BG, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
